// File: rtl/slice_ser_pkg.sv
// Shared types and helpers for the slice serializer.
package slice_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Width of an index able to address n slices.
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/slice_next_finder.sv
// Direction-aware priority search for the next slice to emit.
// With start set the search includes the first scan position; otherwise it
// begins just after cur_idx. When nothing eligible remains, next_idx points at
// the final scan position so an all-zero frame still yields a terminator beat.
module slice_next_finder
    import slice_ser_pkg::*;
#(
    parameter int SLICE_W  = 10,
    parameter int N_SLICES = 48,
    parameter int IDX_W    = idx_w(N_SLICES)
) (
    input  logic [N_SLICES*SLICE_W-1:0] frame,
    input  logic [IDX_W-1:0]            cur_idx,
    input  logic                        start,
    input  logic                        dir,
    input  logic                        skip_zero,
    output logic [IDX_W-1:0]            next_idx,
    output logic                        found,
    output logic                        more
);

    logic [N_SLICES-1:0] elig;
    logic [N_SLICES-1:0] elig_scan;

    // A slice is eligible unless it is zero and zero-skipping is enabled;
    // elig_scan re-orders the mask so that bit 0 is always the first scanned.
    generate
        for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_mask
            assign elig[gi]      = !skip_zero || (frame[gi*SLICE_W +: SLICE_W] != '0);
            assign elig_scan[gi] = dir ? elig[N_SLICES-1-gi] : elig[gi];
        end
    endgenerate

    // Lowest eligible scan position at or after the search origin, plus
    // whether any eligible position follows it.
    always_comb begin
        int cur_pos;
        int lo;
        int pos;
        cur_pos = dir ? (N_SLICES - 1 - int'(cur_idx)) : int'(cur_idx);
        lo      = start ? 0 : cur_pos + 1;
        found   = 1'b0;
        more    = 1'b0;
        pos     = N_SLICES - 1;
        for (int p = N_SLICES - 1; p >= 0; p--) begin
            if (elig_scan[p] && (p >= lo)) begin
                found = 1'b1;
                pos   = p;
            end
        end
        for (int p = 0; p < N_SLICES; p++) begin
            if (elig_scan[p] && (p > pos)) begin
                more = 1'b1;
            end
        end
        next_idx = dir ? IDX_W'(N_SLICES - 1 - pos) : IDX_W'(pos);
    end

endmodule

// File: rtl/slice_serializer.sv
// Captures a wide frame and streams its slices one per cycle with index and
// end-of-frame flag, in either order, optionally skipping zero slices.
module slice_serializer
    import slice_ser_pkg::*;
#(
    parameter int SLICE_W  = 10,
    parameter int N_SLICES = 48,
    parameter int IDX_W    = idx_w(N_SLICES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_SLICES*SLICE_W-1:0] in_data,
    input  logic                        msb_first,
    input  logic                        skip_zero,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W-1:0]          out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy
);

    state_t state, state_next;

    logic [N_SLICES*SLICE_W-1:0] frame_reg;
    logic                        msb_reg;
    logic                        skip_reg;

    logic [N_SLICES*SLICE_W-1:0] sel_frame;
    logic                        sel_dir;
    logic                        sel_skip;
    logic                        start;
    logic [IDX_W-1:0]            next_idx;
    logic                        found;
    logic                        more;
    logic [SLICE_W-1:0]          next_data;
    logic                        capture;
    logic                        fire;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign capture   = (state == IDLE) && in_valid;
    assign fire      = (state == EMIT) && out_ready;

    // In IDLE the finder looks at the live input so the first beat can be
    // loaded on the capture edge; afterwards it works on the frame copy.
    assign start     = (state == IDLE);
    assign sel_frame = start ? in_data   : frame_reg;
    assign sel_dir   = start ? msb_first : msb_reg;
    assign sel_skip  = start ? skip_zero : skip_reg;
    assign next_data = sel_frame[int'(next_idx)*SLICE_W +: SLICE_W];

    slice_next_finder #(
        .SLICE_W  (SLICE_W),
        .N_SLICES (N_SLICES),
        .IDX_W    (IDX_W)
    ) u_finder (
        .frame     (sel_frame),
        .cur_idx   (out_idx),
        .start     (start),
        .dir       (sel_dir),
        .skip_zero (sel_skip),
        .next_idx  (next_idx),
        .found     (found),
        .more      (more)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on capture, return once the last beat is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = EMIT;
            EMIT: if (out_ready && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame copy and registered beat outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
            msb_reg   <= 1'b0;
            skip_reg  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (capture || (fire && !out_last)) begin
            if (capture) begin
                frame_reg <= in_data;
                msb_reg   <= msb_first;
                skip_reg  <= skip_zero;
            end
            out_data <= next_data;
            out_idx  <= next_idx;
            out_last <= !(found && more);
        end else if (fire) begin
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_slice_serializer.sv
// Directed bench for slice_serializer: table of short frames plus
// hand-written full-frame, backpressure and mid-frame reset sequences.
module tb_slice_serializer;

    localparam int W  = 10;
    localparam int N  = 48;
    localparam int IW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    in_data;
    logic              msb_first;
    logic              skip_zero;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    slice_serializer #(.SLICE_W(W), .N_SLICES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .msb_first (msb_first),
        .skip_zero (skip_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [N*W-1:0]   data;
        logic             msb;
        logic             skip;
        int               n;
        logic [3:0][5:0]  idx;
        logic [3:0][9:0]  dat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] ramp(input int base);
        logic [N*W-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[k*W +: W] = W'(k + base);
        return f;
    endfunction

    // Present a frame for one cycle, then scramble the inputs so only the
    // captured copy can produce correct beats. Leaves time at edge+1.
    task automatic capture(input logic [N*W-1:0] d, input logic msb, input logic skip);
        in_data   = d;
        msb_first = msb;
        skip_zero = skip;
        in_valid  = 1'b1;
        chk("in_ready_before_capture", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = '1;
        msb_first = ~msb;
        skip_zero = ~skip;
        chk("first_beat_latency", 32'(out_valid), 32'd1);
        chk("busy_after_capture", 32'(busy), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid_low"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_high"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    // Full 48-beat frame with ready held high; data = idx + base.
    task automatic run_full(input int base, input logic msb);
        int exp_idx;
        out_ready = 1'b1;
        capture(ramp(base), msb, 1'b0);
        for (int i = 0; i < N; i++) begin
            exp_idx = msb ? (N - 1 - i) : i;
            chk("full_valid", 32'(out_valid), 32'd1);
            chk("full_idx", 32'(out_idx), 32'(exp_idx));
            chk("full_data", 32'(out_data), 32'((exp_idx + base) % 1024));
            chk("full_last", 32'(out_last), 32'(i == N - 1));
            @(posedge clk); #1;
        end
        check_idle("full_end");
    endtask

    initial begin
        int exp_b;
        int cyc;

        // Hand-computed short frames (all with zero skipping).
        vecs[0].name = "msb_skip_3";
        vecs[0].data = '0;
        vecs[0].data[3*W +: W]  = 10'h155;
        vecs[0].data[17*W +: W] = 10'h2AA;
        vecs[0].data[40*W +: W] = 10'h001;
        vecs[0].msb = 1'b1; vecs[0].skip = 1'b1; vecs[0].n = 3;
        vecs[0].idx = {6'd0, 6'd3, 6'd17, 6'd40};
        vecs[0].dat = {10'h000, 10'h155, 10'h2AA, 10'h001};

        vecs[1] = vecs[0];
        vecs[1].name = "lsb_skip_3";
        vecs[1].msb = 1'b0;
        vecs[1].idx = {6'd0, 6'd40, 6'd17, 6'd3};
        vecs[1].dat = {10'h000, 10'h001, 10'h2AA, 10'h155};

        vecs[2].name = "allzero_lsb";
        vecs[2].data = '0;
        vecs[2].msb = 1'b0; vecs[2].skip = 1'b1; vecs[2].n = 1;
        vecs[2].idx = {6'd0, 6'd0, 6'd0, 6'd47};
        vecs[2].dat = '0;

        vecs[3] = vecs[2];
        vecs[3].name = "allzero_msb";
        vecs[3].msb = 1'b1;
        vecs[3].idx = '0;

        vecs[4].name = "top_3ff_lsb";
        vecs[4].data = '0;
        vecs[4].data[47*W +: W] = 10'h3FF;
        vecs[4].msb = 1'b0; vecs[4].skip = 1'b1; vecs[4].n = 1;
        vecs[4].idx = {6'd0, 6'd0, 6'd0, 6'd47};
        vecs[4].dat = {10'h000, 10'h000, 10'h000, 10'h3FF};

        vecs[5].name = "bottom_only_msb";
        vecs[5].data = '0;
        vecs[5].data[0 +: W] = 10'h3FF;
        vecs[5].msb = 1'b1; vecs[5].skip = 1'b1; vecs[5].n = 1;
        vecs[5].idx = '0;
        vecs[5].dat = {10'h000, 10'h000, 10'h000, 10'h3FF};

        vecs[6].name = "pair_lsb";
        vecs[6].data = '0;
        vecs[6].data[0 +: W]    = 10'h001;
        vecs[6].data[46*W +: W] = 10'h200;
        vecs[6].msb = 1'b0; vecs[6].skip = 1'b1; vecs[6].n = 2;
        vecs[6].idx = {6'd0, 6'd0, 6'd46, 6'd0};
        vecs[6].dat = {10'h000, 10'h000, 10'h200, 10'h001};

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        msb_first = 1'b0; skip_zero = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_emit", 32'(out_valid), 32'd0);

        // Full LSB-first frame, then an MSB-first one.
        run_full(1, 1'b0);
        run_full(5, 1'b1);

        // Table-driven short frames.
        for (int v = 0; v < 7; v++) begin
            out_ready = 1'b1;
            capture(vecs[v].data, vecs[v].msb, vecs[v].skip);
            for (int b = 0; b < vecs[v].n; b++) begin
                $display("vec %s beat %0d: idx=%0d data=%h last=%0b", vecs[v].name, b,
                         out_idx, out_data, out_last);
                chk({vecs[v].name, "_valid"}, 32'(out_valid), 32'd1);
                chk({vecs[v].name, "_idx"}, 32'(out_idx), 32'(vecs[v].idx[b]));
                chk({vecs[v].name, "_data"}, 32'(out_data), 32'(vecs[v].dat[b]));
                chk({vecs[v].name, "_last"}, 32'(out_last), 32'(b == vecs[v].n - 1));
                @(posedge clk); #1;
            end
            check_idle(vecs[v].name);
        end

        // Backpressure: random ready, beats must hold while stalled.
        out_ready = 1'b0;
        capture(ramp(1), 1'b0, 1'b0);
        exp_b = 0;
        cyc = 0;
        while (exp_b < N && cyc < 2000) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_idx", 32'(out_idx), 32'(exp_b));
            chk("bp_data", 32'(out_data), 32'(exp_b + 1));
            chk("bp_last", 32'(out_last), 32'(exp_b == N - 1));
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (out_ready) exp_b++;
            cyc++;
        end
        chk("bp_completed_in_budget", 32'(exp_b), 32'(N));
        $display("backpressure frame: %0d beats in %0d cycles", exp_b, cyc);
        out_ready = 1'b1;
        check_idle("bp_end");

        // Reset mid-frame at beat 20, then a fresh frame.
        capture(ramp(1), 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_before_rst_idx", 32'(out_idx), 32'd20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_post_rst_no_emit", 32'(out_valid), 32'd0);
        run_full(101, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
